// File: rtl/fft_source_ctrl.sv
// Receive-side controller for the FFT source port: frame checking, bin power, peak report.
// Define FFT_SRC_DC_SKIP_EN to exclude bin 0 (DC) from the peak search.
module fft_source_ctrl #(
  parameter int DATA_W       = 12,
  parameter int FFT_LEN_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      source_valid,
  output logic                      source_ready,
  input  logic                      source_sop,
  input  logic                      source_eop,
  input  logic [1:0]                source_error,
  input  logic [DATA_W-1:0]         source_real,
  input  logic [DATA_W-1:0]         source_imag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_W-1:0]       out_power,
  output logic [FFT_LEN_LOG2-1:0]   out_bin,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      peak_valid,
  output logic [FFT_LEN_LOG2-1:0]   peak_bin,
  output logic [2*DATA_W-1:0]       peak_power,
  output logic                      frame_err
);

  localparam int PWR_W = 2 * DATA_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [FFT_LEN_LOG2-1:0] BIN_ZERO = '0;
  localparam logic [FFT_LEN_LOG2-1:0] BIN_ONE  = FFT_LEN_LOG2'(1);
  localparam logic [FFT_LEN_LOG2-1:0] BIN_LAST = '1;

  logic [0:0]              state_q, state_d;
  logic [FFT_LEN_LOG2-1:0] bin_q, bin_d;
  logic [PWR_W-1:0]        run_pow_q, run_pow_d;
  logic [FFT_LEN_LOG2-1:0] run_bin_q, run_bin_d;

  logic                    out_valid_q, out_valid_d;
  logic [PWR_W-1:0]        out_power_q, out_power_d;
  logic [FFT_LEN_LOG2-1:0] out_bin_q, out_bin_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;

  logic                    peak_valid_q;
  logic [FFT_LEN_LOG2-1:0] peak_bin_q, peak_bin_d;
  logic [PWR_W-1:0]        peak_power_q, peak_power_d;
  logic                    frame_err_q;

  logic                    accept;
  logic                    fwd_beat;
  logic [FFT_LEN_LOG2-1:0] fwd_bin;
  logic                    err_event;
  logic                    good_end;
  logic                    peak_upd;

  // Squares are taken in the full PWR_W width so the (-max,-max) corner cannot wrap.
  logic signed [PWR_W-1:0] re_ext, im_ext;
  logic [PWR_W-1:0]        re_sq, im_sq, beat_pwr;

  assign re_ext   = {{DATA_W{source_real[DATA_W-1]}}, source_real};
  assign im_ext   = {{DATA_W{source_imag[DATA_W-1]}}, source_imag};
  assign re_sq    = re_ext * re_ext;
  assign im_sq    = im_ext * im_ext;
  assign beat_pwr = re_sq + im_sq;

  assign source_ready = !out_valid_q || out_ready;
  assign accept       = source_valid && source_ready;
  assign peak_upd     = beat_pwr > run_pow_q;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    run_pow_d = run_pow_q;
    run_bin_d = run_bin_q;
    fwd_beat  = 1'b0;
    fwd_bin   = BIN_ZERO;
    err_event = 1'b0;
    good_end  = 1'b0;
    if (accept) begin
      if (|source_error) begin
        err_event = 1'b1;
        state_d   = ST_IDLE;
        bin_d     = BIN_ZERO;
      end else if (source_sop) begin
        // A sop inside a frame restarts it; sop+eop together is a one-beat short frame.
        err_event = (state_q == ST_RUN) || source_eop;
        fwd_beat  = 1'b1;
        fwd_bin   = BIN_ZERO;
`ifdef FFT_SRC_DC_SKIP_EN
        run_pow_d = '0;
        run_bin_d = BIN_ONE;
`else
        run_pow_d = beat_pwr;
        run_bin_d = BIN_ZERO;
`endif
        if (source_eop) begin
          state_d = ST_IDLE;
          bin_d   = BIN_ZERO;
        end else begin
          state_d = ST_RUN;
          bin_d   = BIN_ONE;
        end
      end else if (state_q == ST_IDLE) begin
        err_event = 1'b1;
      end else begin
        fwd_beat = 1'b1;
        fwd_bin  = bin_q;
        if (peak_upd) begin
          run_pow_d = beat_pwr;
          run_bin_d = bin_q;
        end
        if (bin_q == BIN_LAST) begin
          good_end  = source_eop;
          err_event = !source_eop;
          state_d   = ST_IDLE;
          bin_d     = BIN_ZERO;
        end else if (source_eop) begin
          err_event = 1'b1;
          state_d   = ST_IDLE;
          bin_d     = BIN_ZERO;
        end else begin
          bin_d = bin_q + BIN_ONE;
        end
      end
    end
  end

  // Output register: a new beat may only load when the held one is consumed or absent.
  always_comb begin
    out_valid_d = out_valid_q;
    out_power_d = out_power_q;
    out_bin_d   = out_bin_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (fwd_beat) begin
      out_valid_d = 1'b1;
      out_power_d = beat_pwr;
      out_bin_d   = fwd_bin;
      out_sop_d   = source_sop;
      out_eop_d   = source_eop;
    end
  end

  always_comb begin
    peak_bin_d   = peak_bin_q;
    peak_power_d = peak_power_q;
    if (good_end) begin
      peak_bin_d   = run_bin_d;
      peak_power_d = run_pow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bin_q        <= BIN_ZERO;
      run_pow_q    <= '0;
      run_bin_q    <= BIN_ZERO;
      out_valid_q  <= 1'b0;
      out_power_q  <= '0;
      out_bin_q    <= BIN_ZERO;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= BIN_ZERO;
      peak_power_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      run_pow_q    <= run_pow_d;
      run_bin_q    <= run_bin_d;
      out_valid_q  <= out_valid_d;
      out_power_q  <= out_power_d;
      out_bin_q    <= out_bin_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      peak_valid_q <= good_end;
      peak_bin_q   <= peak_bin_d;
      peak_power_q <= peak_power_d;
      frame_err_q  <= err_event;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_power  = out_power_q;
  assign out_bin    = out_bin_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_power = peak_power_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_source_ctrl.sv
// Scoreboard bench for fft_source_ctrl (N=16): frame-level reference model, random frames and backpressure.
module tb_fft_source_ctrl;
  localparam int DW = 12;
  localparam int LG = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          source_valid, source_ready, source_sop, source_eop;
  logic [1:0]    source_error;
  logic [DW-1:0] source_real, source_imag;
  logic          out_valid, out_ready, out_sop, out_eop;
  logic [2*DW-1:0] out_power, peak_power;
  logic [LG-1:0] out_bin, peak_bin;
  logic          peak_valid, frame_err;

  fft_source_ctrl #(.DATA_W(DW), .FFT_LEN_LOG2(LG)) dut (
    .clk(clk), .rst_n(rst_n),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop), .source_error(source_error),
    .source_real(source_real), .source_imag(source_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_power(out_power),
    .out_bin(out_bin), .out_sop(out_sop), .out_eop(out_eop),
    .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_power(peak_power),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { longint pw; int bin; bit sop; bit eop; } beat_t;
  typedef struct { longint pw; int bin; } peak_t;
  beat_t exp_q[$];
  peak_t pk_q[$];

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int act_err = 0;

  // Reference model state: whether a frame is open, how many bins it holds, their powers.
  bit     m_in_frame = 0;
  int     m_count = 0;
  longint m_pows[N];

  int rdy_mode = 0;
  int rdy_cnt = 0;
  bit gaps_en = 0;
  int fr_re[N], fr_im[N];

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_close_good();
    peak_t p;
`ifdef FFT_SRC_DC_SKIP_EN
    p.pw = 0; p.bin = 1;
`else
    p.pw = m_pows[0]; p.bin = 0;
`endif
    for (int k = 1; k < N; k++)
      if (m_pows[k] > p.pw) begin p.pw = m_pows[k]; p.bin = k; end
    pk_q.push_back(p);
  endtask

  task automatic model_beat(bit sop, bit eop, logic [1:0] err, int re, int im);
    beat_t b;
    bit e;
    longint pw;
    pw = longint'(re) * re + longint'(im) * im;
    e = 0;
    if (err != 2'b00) begin
      e = 1; m_in_frame = 0;
    end else if (sop || m_in_frame) begin
      if (sop) begin
        if (m_in_frame) e = 1;
        m_count = 0; m_in_frame = 1;
      end
      b.pw = pw; b.bin = m_count; b.sop = sop; b.eop = eop;
      exp_q.push_back(b);
      m_pows[m_count] = pw;
      m_count++;
      if (m_count == N) begin
        if (eop) model_close_good(); else e = 1;
        m_in_frame = 0;
      end else if (eop) begin
        e = 1; m_in_frame = 0;
      end
    end else begin
      e = 1;
    end
    if (e) exp_err++;
  endtask

  task automatic send_beat(bit sop, bit eop, logic [1:0] err, int re, int im);
    bit acc;
    int g;
    g = (gaps_en && ($urandom % 3 == 0)) ? $urandom_range(1, 3) : 0;
    repeat (g) begin
      @(negedge clk);
      source_valid = 1'b0;
      source_real  = DW'($urandom);
    end
    @(negedge clk);
    source_valid = 1'b1; source_sop = sop; source_eop = eop; source_error = err;
    source_real = DW'(re); source_imag = DW'(im);
    acc = 0;
    for (int n = 0; n < 500; n++) begin
      #1;
      if (source_ready) begin acc = 1; break; end
      @(negedge clk);
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no source_ready expected ready within 500 cycles");
    end else begin
      @(posedge clk);
      model_beat(sop, eop, err, re, im);
    end
    #1 source_valid = 1'b0;
  endtask

  // Sends fr_re/fr_im bins 0..nbeats-1; eop on bin eop_at, error code 01 on bin err_at.
  task automatic send_frame(int nbeats, int eop_at, int err_at);
    for (int k = 0; k < nbeats; k++)
      send_beat(k == 0, k == eop_at, (k == err_at) ? 2'b01 : 2'b00, fr_re[k], fr_im[k]);
  endtask

  task automatic fill_random();
    int lim;
    lim = $urandom_range(0, 2);
    for (int k = 0; k < N; k++) begin
      case (lim)
        0: begin fr_re[k] = $urandom_range(0, 3); fr_im[k] = $urandom_range(0, 3); end
        1: begin fr_re[k] = int'($urandom_range(0, 4095)) - 2048; fr_im[k] = int'($urandom_range(0, 4095)) - 2048; end
        default: begin fr_re[k] = ($urandom % 5 == 0) ? -2048 : int'($urandom_range(0, 200)) - 100; fr_im[k] = -2048; end
      endcase
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_peak_valid"}, peak_valid, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_out_power"}, out_power, 0);
    chk({tag, "_out_bin"}, out_bin, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
    chk({tag, "_peak_power"}, peak_power, 0);
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom % 4) != 0;
      default: begin
        out_ready = !(rdy_cnt >= 5 && rdy_cnt < 8);
        rdy_cnt = rdy_cnt + 1;
      end
    endcase
  end

  // Monitor: pops expectations whenever a beat transfers at the coming edge.
  initial begin : monitor
    bit hold;
    longint held;
    beat_t b;
    peak_t p;
    hold = 0; held = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin hold = 0; continue; end
      chk("source_ready", source_ready, !out_valid || out_ready);
      if (hold) chk("hold_stable", {out_power, out_bin, out_sop, out_eop}, held);
      hold = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got bin %0d power %0d expected no beat", out_bin, out_power);
        end else begin
          b = exp_q.pop_front();
          $display("beat bin=%0d power=%0d sop=%0d eop=%0d", out_bin, out_power, out_sop, out_eop);
          chk("out_power", out_power, b.pw);
          chk("out_bin", out_bin, b.bin);
          chk("out_sop", out_sop, b.sop);
          chk("out_eop", out_eop, b.eop);
        end
      end else if (out_valid) begin
        hold = 1;
        held = {out_power, out_bin, out_sop, out_eop};
      end
      if (frame_err) act_err++;
      if (peak_valid) begin
        if (pk_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_peak: got bin %0d power %0d expected no peak", peak_bin, peak_power);
        end else begin
          p = pk_q.pop_front();
          $display("peak bin=%0d power=%0d", peak_bin, peak_power);
          chk("peak_bin", peak_bin, p.bin);
          chk("peak_power", peak_power, p.pw);
        end
      end
    end
  end

  initial begin
    int kind, k;
    rst_n = 1'b0; out_ready = 1'b1;
    source_valid = 0; source_sop = 0; source_eop = 0; source_error = 0;
    source_real = 0; source_imag = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) begin fr_re[i] = i; fr_im[i] = 0; end
    fr_re[9] = 100; fr_im[9] = -50;
    send_frame(N, N - 1, -1);
    drain();
    chk("f1_peak_bin", peak_bin, 9);
    chk("f1_peak_power", peak_power, 12500);

    for (int i = 0; i < N; i++) begin fr_re[i] = i; fr_im[i] = 0; end
    fr_re[3] = -2048; fr_im[3] = -2048;
    send_frame(N, N - 1, -1);
    drain();
    chk("f2_peak_bin", peak_bin, 3);
    chk("f2_peak_power", peak_power, 8388608);

    for (int i = 0; i < N; i++) begin fr_re[i] = i; fr_im[i] = i; end
    rdy_cnt = 0; rdy_mode = 2;
    send_frame(N, N - 1, -1);
    drain();
    rdy_mode = 0;

    send_frame(8, 7, -1);
    for (int i = 0; i < N; i++) begin fr_re[i] = 20 - i; fr_im[i] = 1; end
    send_frame(N, N - 1, -1);
    drain();
    chk("f4_peak_bin", peak_bin, 0);

    send_beat(0, 0, 2'b00, 7, 7);
    send_frame(5, -1, 4);
    drain();

    for (int i = 0; i < N; i++) begin fr_re[i] = 1; fr_im[i] = 0; end
    fr_re[0] = 500; fr_re[7] = 10;
    send_frame(N, N - 1, -1);
    drain();
`ifdef FFT_SRC_DC_SKIP_EN
    chk("dc_peak_bin", peak_bin, 7);
    chk("dc_peak_power", peak_power, 100);
`else
    chk("dc_peak_bin", peak_bin, 0);
    chk("dc_peak_power", peak_power, 250000);
`endif

    fill_random();
    send_frame(6, -1, -1);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    check_reset_outputs("midreset");
    m_in_frame = 0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    send_frame(N, N - 1, -1);
    drain();

    rdy_mode = 1; gaps_en = 1;
    for (int f = 0; f < 60; f++) begin
      fill_random();
      kind = $urandom_range(0, 9);
      k = $urandom_range(0, N - 2);
      case (kind)
        0: send_frame(k + 1, k, -1);
        1: begin send_frame(N, -1, -1); end
        2: send_frame(k + 1, -1, k);
        3: send_beat(0, $urandom_range(0, 1), 2'b00, fr_re[0], fr_im[0]);
        4: begin send_frame(k + 1, -1, -1); send_frame(N, N - 1, -1); end
        default: send_frame(N, N - 1, -1);
      endcase
    end
    drain();

    chk("frame_err_count", act_err, exp_err);
    chk("peaks_pending", pk_q.size(), 0);
    chk("beats_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
